// File: rtl/prores_patch_pkg.sv
// Shared definitions for the size-field patch write path.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package prores_patch_pkg;

  typedef enum logic {
    STATE_IDLE  = 1'b0,
    STATE_WRITE = 1'b1
  } state_t;

  localparam int MAX_PATCH_BYTES = 4;

  // Requester slots in priority order (lower index wins)
  localparam int REQ_SLICE   = 0;
  localparam int REQ_PICTURE = 1;
  localparam int REQ_FRAME   = 2;
  localparam int REQ_Y       = 3;
  localparam int REQ_CB      = 4;

  // A patch field is 1..MAX_PATCH_BYTES bytes wide
  function automatic logic size_legal(input logic [2:0] size);
    return (size >= 3'd1) && (size <= 3'(MAX_PATCH_BYTES));
  endfunction

endpackage

// File: rtl/patch_byte_serializer.sv
// Holds one latched patch and presents its current byte, MSB first, with ascending address.
// Latency: registered; load/advance take effect on the next clock edge.
// Backpressure: the byte is held stable until advance is asserted.
module patch_byte_serializer
  import prores_patch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         advance,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [8*MAX_PATCH_BYTES-1:0] load_val,
  input  logic [2:0]                   load_size,
  output logic [ADDR_W-1:0]            byte_addr,
  output logic [7:0]                   byte_data,
  output logic                         last
);

  logic [8*MAX_PATCH_BYTES-1:0] val_q;
  logic [1:0]                   k_q;
  logic [1:0]                   k_first;

  // size 4 wraps to 3 in two bits, so k_first = size-1 for every legal size
  assign k_first = load_size[1:0] - 2'd1;
  assign last    = (k_q == 2'd0);

  function automatic logic [7:0] pick_byte(input logic [8*MAX_PATCH_BYTES-1:0] v,
                                           input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  // Latch a new patch or step to the next lower byte; the address simply increments (wraps)
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q     <= '0;
      k_q       <= '0;
      byte_addr <= '0;
      byte_data <= '0;
    end else if (load) begin
      val_q     <= load_val;
      k_q       <= k_first;
      byte_addr <= load_addr;
      byte_data <= pick_byte(load_val, k_first);
    end else if (advance) begin
      k_q       <= k_q - 2'd1;
      byte_addr <= byte_addr + ADDR_W'(1);
      byte_data <= pick_byte(val_q, k_q - 2'd1);
    end
  end

endmodule

// File: rtl/patch_write_arbiter.sv
// Fixed-priority arbiter serializing size-field patches into single-byte buffer writes.
// Latency: grant decided in an IDLE cycle; req_ready and the first write appear the next cycle.
// Backpressure: mem_ready stalls a byte in place; bus_hold drops mem_we from the next cycle.
module patch_write_arbiter
  import prores_patch_pkg::*;
#(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_val,
  input  logic [NUM_REQ*3-1:0]    req_byte_size,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    bus_hold,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    busy,
  output logic [15:0]             patch_count,
  output logic                    size_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;
  logic               any_req;
  logic [ADDR_W-1:0]  sel_addr;
  logic [31:0]        sel_val;
  logic [2:0]         sel_size;
  logic               grant_ok;
  logic               sel_legal;
  logic               byte_done;
  logic               ser_last;
  logic               ser_load;
  logic               ser_advance;

  // Lowest-index pending request wins
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) sel_idx = IDX_W'(i);
    end
    any_req    = |req_valid;
    sel_onehot = NUM_REQ'(any_req) << sel_idx;
    sel_addr   = req_addr[32*int'(sel_idx) +: ADDR_W];
    sel_val    = req_val[32*int'(sel_idx) +: 32];
    sel_size   = req_byte_size[3*int'(sel_idx) +: 3];
  end

  // A grant pulse just issued blocks the next grant: this gives the requester time to drop
  // req_valid and forms the one-cycle bubble between patches
  assign grant_ok    = (state == STATE_IDLE) && !bus_hold && any_req && (req_ready == '0);
  assign sel_legal   = size_legal(sel_size);
  assign byte_done   = (state == STATE_WRITE) && mem_we && mem_ready;
  assign ser_load    = grant_ok && sel_legal;
  assign ser_advance = byte_done && !ser_last;
  assign busy        = (state == STATE_WRITE);

  patch_byte_serializer #(
    .ADDR_W(ADDR_W)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .advance   (ser_advance),
    .load_addr (sel_addr),
    .load_val  (sel_val),
    .load_size (sel_size),
    .byte_addr (mem_addr),
    .byte_data (mem_wdata),
    .last      (ser_last)
  );

  // Grant/write FSM; every output it drives is a register
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= STATE_IDLE;
      req_ready   <= '0;
      mem_we      <= 1'b0;
      patch_count <= '0;
      size_error  <= 1'b0;
    end else begin
      req_ready <= '0;
      case (state)
        STATE_IDLE: begin
          mem_we <= 1'b0;
          if (grant_ok) begin
            req_ready <= sel_onehot;
            if (sel_legal) begin
              state  <= STATE_WRITE;
              mem_we <= 1'b1;
            end else begin
              size_error <= 1'b1;
            end
          end
        end
        STATE_WRITE: begin
          if (byte_done && ser_last) begin
            state       <= STATE_IDLE;
            mem_we      <= 1'b0;
            patch_count <= patch_count + 16'd1;
          end else begin
            mem_we <= !bus_hold;
          end
        end
        default: begin
          state  <= STATE_IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_patch_write_arbiter.sv
// Directed bench for patch_write_arbiter with a byte-level expectation queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_patch_write_arbiter;
  import prores_patch_pkg::*;

  localparam int NR = 5;
  localparam int AW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR*32-1:0] req_val;
  logic [NR*3-1:0] req_byte_size;
  logic [NR-1:0]   req_ready;
  logic            bus_hold;
  logic            mem_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wdata;
  logic            busy;
  logic [15:0]     patch_count;
  logic            size_error;

  always #5 clock = ~clock;

  patch_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_val       (req_val),
    .req_byte_size (req_byte_size),
    .req_ready     (req_ready),
    .bus_hold      (bus_hold),
    .mem_ready     (mem_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .patch_count   (patch_count),
    .size_error    (size_error)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  int          nchecks = 0;
  int          nerrors = 0;
  logic [15:0] model_cnt = '0;
  bit          model_err = 0;
  bit          started = 0;
  int          cyc = 0;
  int          wcyc[$];
  logic [31:0] wadr[$];
  logic [7:0]  wdat[$];
  int          gidx[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected byte stream of one patch: ascending addresses, most significant byte first
  function automatic void expect_patch(input logic [31:0] a, input logic [31:0] v, input int n);
    wr_t w;
    for (int j = 0; j < n; j++) begin
      w.a    = a + 32'(j);
      w.d    = 8'(v >> (8 * (n - 1 - j)));
      w.last = (j == n - 1);
      exp_q.push_back(w);
    end
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] v,
                         input logic [2:0] s);
    req_addr[32*i +: 32]     = a;
    req_val[32*i +: 32]      = v;
    req_byte_size[3*i +: 3]  = s;
    req_valid[i]             = 1'b1;
  endtask

  // One cycle; requesters drop valid after the cycle their req_ready was seen
  task automatic tick();
    logic [NR-1:0] got;
    @(negedge clock);
    got = req_ready;
    @(posedge clock);
    #1;
    req_valid = req_valid & ~got;
  endtask

  task automatic clear_logs();
    wcyc.delete();
    wadr.delete();
    wdat.delete();
    gidx.delete();
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int t = 0; t < 60 && !ok; t++) begin
      tick();
      if (!busy && exp_q.size() == 0 && req_valid == '0) ok = 1;
    end
    chk({nm, "_done"}, 64'(ok), 64'd1);
  endtask

  // Per-cycle comparison against the expectation queue and the protocol rules
  logic        prev_hold = 0;
  logic        prev_stall = 0;
  logic [31:0] prev_a;
  logic [7:0]  prev_d;

  always @(negedge clock) begin
    if (started) begin
      if (reset) begin
        exp_q.delete();
        model_cnt = '0;
        model_err = 0;
        prev_hold = 0;
        prev_stall = 0;
      end else begin
        if (req_ready != '0) begin
          int lo;
          logic [NR-1:0] oh;
          logic [2:0] s;
          lo = -1;
          for (int i = NR - 1; i >= 0; i--) if (req_valid[i]) lo = i;
          oh = (lo >= 0) ? NR'(1) << lo : '0;
          chk("grant_onehot", 64'(req_ready), 64'(oh));
          if (lo >= 0) begin
            gidx.push_back(lo);
            s = req_byte_size[3*lo +: 3];
            if (s == 3'd0 || s > 3'd4) model_err = 1;
          end
        end
        chk("size_error", 64'(size_error), 64'(model_err));
        chk("patch_count", 64'(patch_count), 64'(model_cnt));
        if (prev_hold) chk("hold_blocks_we", 64'(mem_we), 64'd0);
        if (prev_stall && mem_we) begin
          chk("stall_addr", 64'(mem_addr), 64'(prev_a));
          chk("stall_data", 64'(mem_wdata), 64'(prev_d));
        end
        if (mem_we && mem_ready) begin
          wcyc.push_back(cyc);
          wadr.push_back(mem_addr);
          wdat.push_back(mem_wdata);
          if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", mem_addr, mem_wdata);
          end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("write_addr", 64'(mem_addr), 64'(w.a));
            chk("write_data", 64'(mem_wdata), 64'(w.d));
            if (w.last) model_cnt = model_cnt + 16'd1;
          end
        end
        prev_hold  = bus_hold;
        prev_stall = mem_we && !mem_ready;
        prev_a     = mem_addr;
        prev_d     = mem_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    req_valid     = '0;
    req_addr      = '0;
    req_val       = '0;
    req_byte_size = '0;
    bus_hold      = 1'b0;
    mem_ready     = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_patch_count", 64'(patch_count), 64'd0);
    chk("rst_size_error", 64'(size_error), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    reset   = 1'b0;
    started = 1;

    // 1: single 4-byte patch from the picture slot
    clear_logs();
    set_req(REQ_PICTURE, 32'h40, 32'h0001_2345, 3'd4);
    expect_patch(32'h40, 32'h0001_2345, 4);
    wait_done("t1");
    chk("t1_nwrites", 64'(wcyc.size()), 64'd4);
    if (wcyc.size() == 4) begin
      chk("t1_consecutive", 64'(wcyc[3] - wcyc[0]), 64'd3);
      chk("t1_addr0", 64'(wadr[0]), 64'h40);
      chk("t1_data0", 64'(wdat[0]), 64'h00);
      chk("t1_data2", 64'(wdat[2]), 64'h23);
      chk("t1_addr3", 64'(wadr[3]), 64'h43);
      chk("t1_data3", 64'(wdat[3]), 64'h45);
    end
    if (gidx.size() > 0) chk("t1_grant_idx", 64'(gidx[0]), 64'd1);
    tick();
    chk("t1_patch_count", 64'(patch_count), 64'd1);

    // 2: simultaneous slot0 and slot4, served in index order with one idle cycle between
    clear_logs();
    set_req(REQ_SLICE, 32'h10, 32'h1234, 3'd2);
    set_req(REQ_CB, 32'h20, 32'hABCD, 3'd2);
    expect_patch(32'h10, 32'h1234, 2);
    expect_patch(32'h20, 32'hABCD, 2);
    wait_done("t2");
    chk("t2_nwrites", 64'(wcyc.size()), 64'd4);
    if (wcyc.size() == 4) begin
      chk("t2_one_idle", 64'(wcyc[2] - wcyc[1]), 64'd2);
      chk("t2_spacing", 64'(wcyc[2] - wcyc[0]), 64'd3);
      chk("t2_addr2", 64'(wadr[2]), 64'h20);
      chk("t2_data2", 64'(wdat[2]), 64'hAB);
      chk("t2_data1", 64'(wdat[1]), 64'h34);
    end
    if (gidx.size() == 2) begin
      chk("t2_first_grant", 64'(gidx[0]), 64'd0);
      chk("t2_second_grant", 64'(gidx[1]), 64'd4);
    end else chk("t2_ngrants", 64'(gidx.size()), 64'd2);
    tick();
    chk("t2_patch_count", 64'(patch_count), 64'd3);

    // 3: bus_hold for 3 cycles after byte 1, then mem_ready low for 2 cycles
    clear_logs();
    set_req(REQ_Y, 32'h100, 32'h1122_3344, 3'd4);
    expect_patch(32'h100, 32'h1122_3344, 4);
    tick();
    tick();
    bus_hold = 1'b1;
    repeat (3) tick();
    bus_hold = 1'b0;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    mem_ready = 1'b1;
    wait_done("t3");
    chk("t3_nwrites", 64'(wcyc.size()), 64'd4);
    if (wcyc.size() == 4) begin
      chk("t3_gap", 64'(wcyc[2] - wcyc[1]), 64'd6);
      chk("t3_resume", 64'(wcyc[3] - wcyc[2]), 64'd1);
      chk("t3_data2", 64'(wdat[2]), 64'h33);
      chk("t3_addr2", 64'(wadr[2]), 64'h102);
    end

    // 4: address wrap across 2^32
    clear_logs();
    set_req(REQ_FRAME, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 3'd4);
    expect_patch(32'hFFFF_FFFE, 32'hDEAD_BEEF, 4);
    wait_done("t4");
    chk("t4_nwrites", 64'(wcyc.size()), 64'd4);
    if (wcyc.size() == 4) begin
      chk("t4_addr1", 64'(wadr[1]), 64'hFFFF_FFFF);
      chk("t4_addr2", 64'(wadr[2]), 64'h0);
      chk("t4_data2", 64'(wdat[2]), 64'hBE);
      chk("t4_addr3", 64'(wadr[3]), 64'h1);
    end

    // 5: illegal size 0 on slot2: pulse, no write, sticky error
    clear_logs();
    set_req(REQ_FRAME, 32'h300, 32'h55, 3'd0);
    repeat (4) tick();
    chk("t5_size_error", 64'(size_error), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_nwrites", 64'(wcyc.size()), 64'd0);
    chk("t5_ngrants", 64'(gidx.size()), 64'd1);
    if (gidx.size() > 0) chk("t5_grant_idx", 64'(gidx[0]), 64'd2);

    // 6: reset in the middle of a 4-byte patch, then a clean restart
    clear_logs();
    set_req(REQ_SLICE, 32'h200, 32'hCAFE_F00D, 3'd4);
    expect_patch(32'h200, 32'hCAFE_F00D, 4);
    tick();
    tick();
    tick();
    chk("t6_error_sticky", 64'(size_error), 64'd1);
    chk("t6_midpatch_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_mem_we", 64'(mem_we), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_patch_count", 64'(patch_count), 64'd0);
    chk("t6_rst_size_error", 64'(size_error), 64'd0);
    chk("t6_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("t6_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    clear_logs();
    set_req(REQ_SLICE, 32'h200, 32'hCAFE_F00D, 3'd4);
    expect_patch(32'h200, 32'hCAFE_F00D, 4);
    wait_done("t6");
    chk("t6_nwrites", 64'(wcyc.size()), 64'd4);
    if (wcyc.size() == 4) begin
      chk("t6_addr0", 64'(wadr[0]), 64'h200);
      chk("t6_data0", 64'(wdat[0]), 64'hCA);
      chk("t6_data3", 64'(wdat[3]), 64'h0D);
    end
    tick();
    chk("t6_patch_count", 64'(patch_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
